timer_scheduler: RTL
====================

// Module: timer_scheduler
// PURPOSE
//  Multiplexes NUM_CH software timers onto one shared prescaler tick, for smart-car periodic tasks
//  (sensor poll, PWM update, watchdog). Each channel is configured at runtime with a period in
//  ticks and a mode (one-shot or periodic). Expiries become pending events. A round-robin
//  arbiter delivers them one at a time over a valid/ready port to the control FSM.
// PARAMETERS
//  NUM_CH    4        number of timer channels (>=2)
//  TICK_DIV  100_000  clk cycles per tick (1 ms @ 100 MHz)
//  PERIOD_W  16       width of channel period / countdown in ticks
//  CH_W      $clog2(NUM_CH)  channel index width (derived, not overridden)
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst         in   1         asynchronous, active-low reset
//  cfg_we      in   1         config write strobe, one cycle
//  cfg_ch      in   CH_W      channel being written
//  cfg_en      in   1         1 = arm channel, 0 = disarm channel
//  cfg_mode    in   1         0 = one-shot, 1 = periodic
//  cfg_period  in   PERIOD_W  period in ticks
//  evt_valid   out  1         event presented
//  evt_ch      out  CH_W      channel of presented event
//  evt_ready   in   1         consumer accepts event
//  active      out  NUM_CH    per-channel armed flag
//  overrun     out  NUM_CH    sticky: expiry occurred while the event was still pending
//  ovr_clr     in   1         clears all overrun bits
// BEHAVIOUR
//  - Reset (async, rst=0): all outputs 0; prescaler, countdowns, pending, RR pointer = 0.
//  - Tick: one-cycle pulse every TICK_DIV clk cycles. The first tick comes TICK_DIV cycles after rst releases.
//  - Arm (cfg_we & cfg_en & cfg_period!=0): remaining<=cfg_period, mode latched, active=1.
//    Clears this channel's pending bit. Re-arming an active channel restarts it.
//  - Arm with cfg_period==0: write ignored; channel state unchanged.
//  - Disarm (cfg_we & !cfg_en): active=0, remaining=0, pending cleared; overrun untouched.
//  - On a tick, each active channel decrements remaining. A channel expires on a tick where remaining==1.
//    Expiry sets pending. Periodic: remaining reloads to period. One-shot: active clears.
//  - Expiry while pending already set: overrun bit set; still only one event pending (no queueing).
//  - cfg_we to a channel on the same cycle as its expiry: the config wins and the expiry is discarded.
//  - Expiry on the handshake cycle of the same channel: pending re-set; overrun not set.
//  - ovr_clr on the same cycle as an overrun set: set wins.
//  - Output port (registered):
//    - When idle, the RR arbiter picks the first pending channel at or after ptr (wrapping) and asserts evt_valid.
//    - Latency: pending set at cycle T -> evt_valid at T+1.
//    - While evt_valid & !evt_ready, evt_valid and evt_ch stay stable. This holds even if the channel is disarmed.
//    - Handshake (evt_valid & evt_ready) at cycle H: pending[evt_ch] clears and ptr<=evt_ch+1 (mod NUM_CH).
//      evt_valid=0 at H+1. The next event is presented at H+2 at the earliest.
//  - Countdown arithmetic is unsigned PERIOD_W, with no wrap: remaining never decrements below 1 while active.
// STRUCTURE
//  - Package timer_pkg: MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1; default TICK_DIV and PERIOD_W constants.
//  - Prescaler: the team's existing timer module (div_value=TICK_DIV), with its reset driven by ~rst.
//  - Sub-module rr_arbiter #(N): pending vector + ptr -> grant index + grant valid, combinational.
//  - Top level holds the per-channel countdown/mode/pending registers and the output register.
// TESTING (bench: NUM_CH=4, TICK_DIV=4, PERIOD_W=8)
//  1. Periodic: arm ch1 period 3, ready=1 -> evt_ch=1 pulse every 12 clk; active=4'b0010 throughout.
//  2. One-shot: arm ch2 period 2 mode 0 -> exactly one event on ch2; active[2]=0 at expiry; none over 20 ticks.
//  3. Contention: ch0 and ch3 expire on the same tick with ready=0 for 5 cycles -> evt_ch=0 held stable.
//     After accept: gap cycle, then evt_ch=3, then ptr=0.
//  4. Overrun: periodic ch3 period 1, ready=0 for 3 ticks -> one event only, overrun=4'b1000.
//     ovr_clr -> overrun=0.
//  5. Corners: arm with period 0 -> active stays 0. Disarm on the expiry cycle -> no event, no overrun.
//  6. Reset mid-run: drop rst while evt_valid=1 -> all outputs 0 asynchronously.
//     After release, no event before the first tick.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer scheduler: channel modes and default sizing.
// No logic; pure declarations.
// No flow control.
package timer_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int TICK_DIV_DEF = 100_000;
    localparam int PERIOD_W_DEF = 16;

endpackage

// File: rtl/timer.sv
// Prescaler: emits a one-cycle tick every div_value clocks, first tick div_value cycles after reset.
// Latency: tick is decoded straight from the counter register.
// No backpressure; free-running.
module timer #(
    parameter int unsigned div_value = 100_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (div_value > 1) ? $clog2(div_value) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(div_value - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr_i, wrapping.
// Latency: combinational.
// No flow control; caller decides when to take the grant.
module rr_arbiter
    import timer_pkg::*;
#(
    parameter int  N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    output logic [CW-1:0] gnt_o,
    output logic          gnt_vld_o
);

    logic [CW-1:0] idx;

    // Scan from the farthest candidate back to ptr so the last hit is the winner.
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = CW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                gnt_o     = idx;
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Multiplexes NUM_CH countdown timers on a shared tick; expiries become pending events sent round-robin.
// Latency: pending set in cycle T -> evt_valid in T+1; at most one event per two cycles.
// Backpressure: evt_valid/evt_ch hold until evt_ready; repeat expiries while pending set overrun.
module timer_scheduler
    import timer_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  TICK_DIV = TICK_DIV_DEF,
    parameter int  PERIOD_W = PERIOD_W_DEF,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_en,
    input  logic                cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                evt_valid,
    output logic [CH_W-1:0]     evt_ch,
    input  logic                evt_ready,
    output logic [NUM_CH-1:0]   active,
    output logic [NUM_CH-1:0]   overrun,
    input  logic                ovr_clr
);

    logic tick;

    timer #(
        .div_value(TICK_DIV)
    ) u_presc (
        .clk_i (clk),
        .rst_i (~rst),
        .tick_o(tick)
    );

    logic [NUM_CH-1:0]   active_q, active_d;
    logic [NUM_CH-1:0]   mode_q, mode_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   ovr_q, ovr_d;
    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] period_d [NUM_CH];
    logic [PERIOD_W-1:0] remain_q [NUM_CH];
    logic [PERIOD_W-1:0] remain_d [NUM_CH];

    logic                evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;

    logic                hs;
    logic [NUM_CH-1:0]   cfg_hit;
    logic [NUM_CH-1:0]   hs_ch;
    logic [CH_W-1:0]     gnt;
    logic                gnt_vld;

    assign hs = evt_valid_q & evt_ready;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .req_i    (pend_q),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_vld_o(gnt_vld)
    );

    // An arm with period 0 is not a write at all, so it cannot mask a same-cycle expiry.
    always_comb begin
        active_d = active_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
        period_d = period_q;
        remain_d = remain_q;
        cfg_hit  = '0;
        hs_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i)) && !(cfg_en && (cfg_period == '0));
            hs_ch[i]   = hs && (evt_ch_q == CH_W'(i));
            if (hs_ch[i]) begin
                pend_d[i] = 1'b0;
            end
            if (ovr_clr) begin
                ovr_d[i] = 1'b0;
            end
            if (cfg_hit[i]) begin
                pend_d[i] = 1'b0;
                if (cfg_en) begin
                    active_d[i] = 1'b1;
                    mode_d[i]   = cfg_mode;
                    period_d[i] = cfg_period;
                    remain_d[i] = cfg_period;
                end else begin
                    active_d[i] = 1'b0;
                    remain_d[i] = '0;
                end
            end else if (tick && active_q[i]) begin
                if (remain_q[i] == PERIOD_W'(1)) begin
                    pend_d[i] = 1'b1;
                    if (pend_q[i] && !hs_ch[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                    if (mode_q[i] == MODE_PERIODIC) begin
                        remain_d[i] = period_q[i];
                    end else begin
                        active_d[i] = 1'b0;
                        remain_d[i] = '0;
                    end
                end else begin
                    remain_d[i] = remain_q[i] - PERIOD_W'(1);
                end
            end
        end
    end

    // Arbitrate only when idle; a presented event is frozen until accepted.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        ptr_d       = ptr_q;
        if (hs) begin
            evt_valid_d = 1'b0;
            ptr_d       = (evt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : evt_ch_q + CH_W'(1);
        end else if (!evt_valid_q && gnt_vld) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q    <= '0;
            mode_q      <= '0;
            pend_q      <= '0;
            ovr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            ptr_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                remain_q[i] <= '0;
            end
        end else begin
            active_q    <= active_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            ptr_q       <= ptr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                remain_q[i] <= remain_d[i];
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign active    = active_q;
    assign overrun   = ovr_q;

endmodule
